// File: rtl/hopfield_sequencer.sv
// hopfield_sequencer: train/recall phase controller for a spiking Hopfield network
module hopfield_sequencer #(
    parameter int N          = 7,
    parameter int NUM_PAT    = 4,
    parameter int EPOCHS     = 4,
    parameter int TRAIN_CYC  = 64,
    parameter int GAP_CYC    = 16,
    parameter int CUE_CYC    = 8,
    parameter int RECALL_CYC = 128,
    parameter int CNT_W      = 8,
    parameter int THRESH     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         recall_only,
    input  logic         abort,
    input  logic         pat_wr_en,
    input  logic [1:0]   pat_wr_addr,
    input  logic [3:0]   pat_wr_data,
    input  logic [3:0]   cue,
    input  logic [N-1:0] net_spikes,
    output logic         learning_enable,
    output logic [3:0]   pattern_input,
    output logic         busy,
    output logic [2:0]   phase,
    output logic         done,
    output logic         result_valid,
    output logic [N-1:0] result
);
    localparam int PW = NUM_PAT > 1 ? $clog2(NUM_PAT) : 1;
    localparam int EW = EPOCHS > 1 ? $clog2(EPOCHS) : 1;
    localparam int TW = 16;
    localparam logic [PW-1:0] LAST_PAT = PW'(NUM_PAT - 1);
    localparam logic [EW-1:0] LAST_EP = EW'(EPOCHS - 1);
    localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);

    typedef enum logic [2:0] {IDLE = 3'd0, TRAIN, GAP, CUE, COUNT, DONE} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [PW-1:0]    pat_idx_q, pat_idx_d;
    logic [EW-1:0]    epoch_q, epoch_d;
    logic [3:0]       cue_q, cue_d;
    logic [3:0]       mem_q [NUM_PAT];
    logic [3:0]       mem_d [NUM_PAT];
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [CNT_W-1:0] cnt_inc [N];
    logic             le_q, le_d, busy_q, busy_d, done_q, done_d, rv_q, rv_d;
    logic [3:0]       pi_q, pi_d;
    logic [N-1:0]     result_q, result_d, hit;
    logic             last;

    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < NUM_PAT; k++)
            if (state_q == IDLE && pat_wr_en && 32'(pat_wr_addr) == k) mem_d[k] = pat_wr_data;
        // hit includes this cycle's spikes so the final COUNT cycle is counted
        for (int i = 0; i < N; i++) begin
            cnt_inc[i] = (net_spikes[i] && cnt_q[i] != '1) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
            hit[i] = cnt_inc[i] >= TH;
        end
        last = timer_q == '0;
        state_d = state_q;
        timer_d = last ? timer_q : timer_q - TW'(1);
        pat_idx_d = pat_idx_q;
        epoch_d = epoch_q;
        cue_d = cue_q;
        cnt_d = cnt_q;
        le_d = le_q;
        pi_d = pi_q;
        done_d = 1'b0;
        rv_d = rv_q;
        result_d = result_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            le_d = 1'b0;
            pi_d = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    cue_d = cue;
                    rv_d = 1'b0;
                    result_d = '0;
                    pat_idx_d = '0;
                    epoch_d = '0;
                    le_d = 1'b1;
                    state_d = recall_only ? CUE : TRAIN;
                    timer_d = recall_only ? TW'(CUE_CYC - 1) : TW'(TRAIN_CYC - 1);
                    pi_d = recall_only ? cue : mem_d[0];
                end
                TRAIN: if (last) begin
                    state_d = GAP;
                    timer_d = TW'(GAP_CYC - 1);
                    le_d = 1'b0;
                    pi_d = '0;
                end
                GAP: if (last) begin
                    state_d = TRAIN;
                    timer_d = TW'(TRAIN_CYC - 1);
                    le_d = 1'b1;
                    if (pat_idx_q != LAST_PAT) pat_idx_d = pat_idx_q + PW'(1);
                    else if (epoch_q != LAST_EP) begin
                        pat_idx_d = '0;
                        epoch_d = epoch_q + EW'(1);
                    end else begin
                        state_d = CUE;
                        timer_d = TW'(CUE_CYC - 1);
                    end
                    pi_d = state_d == CUE ? cue_q : mem_d[pat_idx_d];
                end
                CUE: if (last) begin
                    state_d = COUNT;
                    timer_d = TW'(RECALL_CYC - 1);
                    le_d = 1'b0;
                    pi_d = '0;
                    cnt_d = '{default: '0};
                end
                COUNT: begin
                    cnt_d = cnt_inc;
                    if (last) begin
                        state_d = DONE;
                        done_d = 1'b1;
                        rv_d = 1'b1;
                        result_d = hit;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            pat_idx_q <= '0;
            epoch_q <= '0;
            cue_q <= '0;
            mem_q <= '{default: '0};
            cnt_q <= '{default: '0};
            le_q <= 1'b0;
            pi_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rv_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pat_idx_q <= pat_idx_d;
            epoch_q <= epoch_d;
            cue_q <= cue_d;
            mem_q <= mem_d;
            cnt_q <= cnt_d;
            le_q <= le_d;
            pi_q <= pi_d;
            busy_q <= busy_d;
            done_q <= done_d;
            rv_q <= rv_d;
            result_q <= result_d;
        end
    end

    assign learning_enable = le_q;
    assign pattern_input = pi_q;
    assign busy = busy_q;
    assign phase = state_q;
    assign done = done_q;
    assign result_valid = rv_q;
    assign result = result_q;
endmodule

// File: tb/tb_hopfield_sequencer.sv
// tb_hopfield_sequencer: table-driven runs checked cycle by cycle against an expected-state queue
module tb_hopfield_sequencer;
    localparam int NP = 2, EP = 1, TC = 4, GC = 2, CC = 2, RC = 8, CW = 3, TH = 4;

    logic       clk = 0, reset = 1, start = 0, recall_only = 0, abort = 0, pat_wr_en = 0;
    logic [1:0] pat_wr_addr = 0;
    logic [3:0] pat_wr_data = 0, cue = 0;
    logic [6:0] net_spikes = 0;
    logic       learning_enable, busy, done, result_valid;
    logic [3:0] pattern_input;
    logic [2:0] phase;
    logic [6:0] result;

    hopfield_sequencer #(
        .N(7), .NUM_PAT(NP), .EPOCHS(EP), .TRAIN_CYC(TC), .GAP_CYC(GC),
        .CUE_CYC(CC), .RECALL_CYC(RC), .CNT_W(CW), .THRESH(TH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .recall_only(recall_only), .abort(abort),
        .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr), .pat_wr_data(pat_wr_data),
        .cue(cue), .net_spikes(net_spikes), .learning_enable(learning_enable),
        .pattern_input(pattern_input), .busy(busy), .phase(phase), .done(done),
        .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic       bz;
        logic       le;
        logic [3:0] pi;
        logic       dn;
        logic       rv;
    } obs_t;

    typedef struct {
        string      tag;
        logic       ro;
        logic [3:0] cue;
        logic       wr;
        logic [1:0] wa;
        logic [3:0] wd;
        int         poke;
        logic [6:0] a;
        int         a_s, a_n;
        logic [6:0] b;
        int         b_s, b_n;
        logic [6:0] exp;
    } rec_t;

    obs_t       exp_q[$];
    logic [3:0] mm [4];
    rec_t       tbl [5];
    int         checks = 0, errors = 0;

    function automatic rec_t mk(string tag, logic ro, logic [3:0] c, logic wr, logic [1:0] wa,
                                logic [3:0] wd, int poke, logic [6:0] a, int a_s, int a_n,
                                logic [6:0] b, int b_s, int b_n, logic [6:0] exp);
        rec_t r;
        r.tag = tag; r.ro = ro; r.cue = c; r.wr = wr; r.wa = wa; r.wd = wd; r.poke = poke;
        r.a = a; r.a_s = a_s; r.a_n = a_n; r.b = b; r.b_s = b_s; r.b_n = b_n; r.exp = exp;
        return r;
    endfunction

    function automatic obs_t obs();
        return {phase, busy, learning_enable, pattern_input, done, result_valid};
    endfunction

    // spikes outside the counting window are all ones and must not be counted
    function automatic logic [6:0] spk(rec_t r, int j);
        if (j < 0 || j >= RC) return 7'h7F;
        return ((j >= r.a_s && j < r.a_s + r.a_n) ? r.a : 7'h00) |
               ((j >= r.b_s && j < r.b_s + r.b_n) ? r.b : 7'h00);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] ph, input logic le, input logic [3:0] pi,
                        input logic dn, input logic rv, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({ph, ph != 3'd0, le, pi, dn, rv});
    endtask

    task automatic expect_run(input logic [3:0] c, input logic ro);
        if (!ro)
            for (int e = 0; e < EP; e++)
                for (int p = 0; p < NP; p++) begin
                    push(3'd1, 1'b1, mm[p], 1'b0, 1'b0, TC);
                    push(3'd2, 1'b0, 4'h0, 1'b0, 1'b0, GC);
                end
        push(3'd3, 1'b1, c, 1'b0, 1'b0, CC);
        push(3'd4, 1'b0, 4'h0, 1'b0, 1'b0, RC);
        push(3'd5, 1'b0, 4'h0, 1'b1, 1'b1, 1);
        push(3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 1);
    endtask

    task automatic write(input logic [1:0] a, input logic [3:0] d);
        pat_wr_en = 1; pat_wr_addr = a; pat_wr_data = d; mm[a] = d;
        tick();
        pat_wr_en = 0;
    endtask

    task automatic run(input rec_t r);
        int L, i, dk;
        obs_t e, o;
        L = r.ro ? 0 : NP * EP * (TC + GC);
        if (r.wr) begin
            pat_wr_en = 1; pat_wr_addr = r.wa; pat_wr_data = r.wd; mm[r.wa] = r.wd;
        end
        cue = r.cue; recall_only = r.ro; start = 1;
        expect_run(r.cue, r.ro);
        dk = -1; i = 0;
        while (exp_q.size() > 0) begin
            net_spikes = spk(r, i - (L + CC + 1));
            if (i == r.poke) begin
                start = 1; pat_wr_en = 1; pat_wr_addr = 2'd0; pat_wr_data = 4'b1111;
            end
            tick();
            start = 0; pat_wr_en = 0;
            e = exp_q.pop_front();
            o = obs();
            chk($sformatf("%s cyc%0d", r.tag, i), 32'(o), 32'(e));
            if (i == 0) chk({r.tag, " result_cleared"}, 32'(result), 32'd0);
            if (o.dn) begin
                dk = i;
                chk({r.tag, " result"}, 32'(result), 32'(r.exp));
            end
            i++;
        end
        chk({r.tag, " done_latency"}, 32'(dk + 1), 32'(L + CC + RC + 1));
        net_spikes = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int any;
        for (int k = 0; k < 4; k++) mm[k] = 4'h0;
        tbl[0] = mk("train",    1'b0, 4'b1000, 1'b0, 2'd0, 4'h0, -1, 7'h01, 0, 8, 7'h02, 0, 3, 7'h01);
        tbl[1] = mk("busy_ign", 1'b0, 4'b0011, 1'b0, 2'd0, 4'h0,  2, 7'h7F, 0, 8, 7'h00, 0, 0, 7'h7F);
        tbl[2] = mk("recall",   1'b1, 4'b0110, 1'b0, 2'd0, 4'h0, -1, 7'h04, 0, 4, 7'h08, 0, 3, 7'h04);
        tbl[3] = mk("last_cyc", 1'b1, 4'b1111, 1'b0, 2'd0, 4'h0, -1, 7'h20, 4, 4, 7'h40, 7, 1, 7'h20);
        tbl[4] = mk("wr_start", 1'b0, 4'b0001, 1'b1, 2'd1, 4'b1100, -1, 7'h00, 0, 0, 7'h00, 0, 0, 7'h00);

        repeat (3) tick();
        reset = 0;
        chk("reset outputs", 32'(obs()), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        write(2'd0, 4'b1010);
        write(2'd1, 4'b0101);
        for (int t = 0; t < 5; t++) run(tbl[t]);

        cue = 4'b1000; recall_only = 0; start = 1;
        tick();
        start = 0;
        chk("abort pre", 32'(phase), 32'd1);
        tick();
        abort = 1;
        tick();
        abort = 0;
        chk("abort outputs", 32'(obs()), 32'd0);
        any = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (done || phase != 3'd0) any = 1;
        end
        chk("abort quiet", 32'(any), 32'd0);
        run(tbl[0]);

        cue = 4'b0110; recall_only = 1; start = 1;
        tick();
        start = 0;
        tick();
        tick();
        chk("reset pre phase", 32'(phase), 32'd4);
        reset = 1;
        tick();
        reset = 0;
        chk("midrun reset outputs", 32'(obs()), 32'd0);
        chk("midrun reset result", 32'(result), 32'd0);
        for (int k = 0; k < 4; k++) mm[k] = 4'h0;
        run(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
